// File: rtl/lifo_pop_streamer_pkg.sv
// Shared definitions for the LIFO pop streamer: data width default,
// FSM state encoding and the legal range of the LIFO read latency.
package lifo_pkg;

  localparam int LIFO_DATA_W  = 8;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Output buffer depth: enough room for every word that can be in the
  // LIFO read pipeline plus the one being presented downstream.
  function automatic int buf_depth(input int read_lat);
    return read_lat + 1;
  endfunction

endpackage

// File: rtl/lifo_pop_streamer_if.sv
// Byte stream from the pop streamer to the next stage.
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1; once out_valid is raised, out_valid and out_data
// stay stable until that transfer happens; out_ready may change freely.
interface lifo_pop_streamer_if #(
  parameter int DATA_W = lifo_pkg::LIFO_DATA_W
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/lifo_pop_streamer_skid_fifo.sv
// Small circular buffer that catches words leaving the LIFO read pipeline
// and presents the oldest one as the stream head.
module pop_skid_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  // Storage and pointers; reset clears the contents so the head reads zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/lifo_pop_streamer.sv
// Drains an 8-bit LIFO on request: issues rn pops with credit-based flow
// control, absorbs the LIFO read latency, and streams the popped bytes
// (last-in first) over a valid/ready interface, reporting count and done.
module lifo_pop_streamer
  import lifo_pkg::*;
#(
  parameter int DATA_W   = LIFO_DATA_W,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       drain,
  input  logic [DATA_W-1:0]          lifo_dataout,
  input  logic                       lifo_empty,
  output logic                       lifo_rn,
  lifo_pop_streamer_if.master        strm,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           pop_count,
  output state_t                     dbg_state
);

  // Out-of-range latencies are pulled into the supported range
  localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
  localparam int BUF_DEPTH = buf_depth(LAT);
  localparam int FCNT_W    = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W     = FCNT_W + 1;

  state_t             state_q;
  logic [CNT_W-1:0]   pop_count_q;
  logic [LAT-1:0]     infl_q;
  logic [LAT-1:0]     infl_d;
  logic [OCC_W-1:0]   infl_cnt;
  logic [OCC_W-1:0]   buf_next;
  logic [FCNT_W-1:0]  fifo_cnt;
  logic [DATA_W-1:0]  fifo_head;
  logic               arrive;
  logic               hs;
  logic               credit_ok;
  logic               flush_clear;

  assign hs     = strm.out_valid && strm.out_ready;
  assign arrive = infl_q[LAT-1];

  // Number of pops still travelling through the LIFO read pipeline
  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < LAT; i++) infl_cnt = infl_cnt + OCC_W'(infl_q[i]);
  end

  // Credit, pop strobe and next-cycle occupancy used by the FSM
  always_comb begin
    credit_ok   = (infl_cnt + OCC_W'(fifo_cnt) - OCC_W'(hs)) < OCC_W'(BUF_DEPTH);
    lifo_rn     = (state_q == ST_DRAIN) && !lifo_empty && credit_ok;
    infl_d      = LAT'({infl_q, lifo_rn});
    buf_next    = OCC_W'(fifo_cnt) + OCC_W'(arrive) - OCC_W'(hs);
    flush_clear = (infl_d == '0) && (buf_next == '0);
  end

  // FSM, pop counter and in-flight shift register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pop_count_q <= '0;
      infl_q      <= '0;
    end else begin
      infl_q <= infl_d;
      case (state_q)
        ST_IDLE: begin
          if (drain) begin
            state_q     <= ST_DRAIN;
            pop_count_q <= '0;
          end
        end
        ST_DRAIN: if (lifo_empty && !lifo_rn) state_q <= ST_FLUSH;
        // Look at next-cycle occupancy so done lands right after the last transfer
        ST_FLUSH: if (flush_clear) state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
      if (lifo_rn && (pop_count_q != '1)) pop_count_q <= pop_count_q + 1'b1;
    end
  end

  pop_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .CNT_W  (FCNT_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (arrive),
    .push_data_i (lifo_dataout),
    .pop_i       (hs),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt)
  );

  assign strm.out_data  = fifo_head;
  assign strm.out_valid = (fifo_cnt != '0);
  assign busy           = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
  assign done           = (state_q == ST_DONE);
  assign pop_count      = pop_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// Bench for lifo_pop_streamer: two instances (READ_LAT 1 and 2), each fed by
// a behavioural LIFO; a scoreboard queue per instance checks the stream.
module tb_lifo_pop_streamer;
  import lifo_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] words [7] = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

  // ---------------- DUT A (READ_LAT = 1) ----------------
  lifo_pop_streamer_if #(.DATA_W(DW)) sa ();
  logic          drain_a = 1'b0;
  logic [DW-1:0] dout_a  = '0;
  logic          empty_a;
  logic          rn_a, busy_a, done_a;
  logic [CW-1:0] pcnt_a;
  state_t        st_a;

  lifo_pop_streamer #(.DATA_W(DW), .READ_LAT(1), .CNT_W(CW)) u_dut_a (
    .clock(clock), .reset(reset), .drain(drain_a), .lifo_dataout(dout_a),
    .lifo_empty(empty_a), .lifo_rn(rn_a), .strm(sa), .busy(busy_a),
    .done(done_a), .pop_count(pcnt_a), .dbg_state(st_a)
  );

  // ---------------- DUT B (READ_LAT = 2) ----------------
  lifo_pop_streamer_if #(.DATA_W(DW)) sb ();
  logic          drain_b = 1'b0;
  logic [DW-1:0] dout_b  = '0;
  logic          empty_b;
  logic          rn_b, busy_b, done_b;
  logic [CW-1:0] pcnt_b;
  state_t        st_b;

  lifo_pop_streamer #(.DATA_W(DW), .READ_LAT(2), .CNT_W(CW)) u_dut_b (
    .clock(clock), .reset(reset), .drain(drain_b), .lifo_dataout(dout_b),
    .lifo_empty(empty_b), .lifo_rn(rn_b), .strm(sb), .busy(busy_b),
    .done(done_b), .pop_count(pcnt_b), .dbg_state(st_b)
  );

  // ---------------- LIFO models ----------------
  logic [DW-1:0] mem_a [16];
  int            ptr_a    = 0;
  int            pops_a   = 0;
  logic          push_a   = 1'b0;
  logic [DW-1:0] push_d_a = '0;

  // Latency 1: DATAOUT is registered at the edge that samples rn
  always @(posedge clock) begin
    if (push_a) begin
      mem_a[ptr_a] <= push_d_a;
      ptr_a        <= ptr_a + 1;
    end else if (rn_a && ptr_a > 0) begin
      dout_a <= mem_a[ptr_a-1];
      ptr_a  <= ptr_a - 1;
      pops_a <= pops_a + 1;
    end
  end
  assign empty_a = (ptr_a == 0);

  logic [DW-1:0] mem_b [16];
  int            ptr_b    = 0;
  logic          push_b   = 1'b0;
  logic [DW-1:0] push_d_b = '0;
  logic [DW-1:0] stage_b  = '0;

  // Latency 2: one extra register stage before DATAOUT
  always @(posedge clock) begin
    dout_b <= stage_b;
    if (push_b) begin
      mem_b[ptr_b] <= push_d_b;
      ptr_b        <= ptr_b + 1;
    end else if (rn_b && ptr_b > 0) begin
      stage_b <= mem_b[ptr_b-1];
      ptr_b   <= ptr_b - 1;
    end
  end
  assign empty_b = (ptr_b == 0);

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int   first_v_a = -1, last_hs_a = -1, done_cnt_a = 0, done_cyc_a = -1;
  int   rn_seen_a = 0, hs_a = 0, drop_a = 0;
  logic prev_stall_a = 1'b0;
  logic [DW-1:0] prev_data_a = '0;

  // Monitor A: stream order, hold-under-backpressure, outstanding bound, done
  always @(negedge clock) begin
    if (reset) begin
      prev_stall_a = 1'b0;
    end else begin
      if (prev_stall_a)
        check("hold_a", {sa.out_valid, sa.out_data}, {1'b1, prev_data_a});
      if (busy_a)
        check("outstanding_a", 32'(pops_a - hs_a - drop_a <= 2), 1);
      if (sa.out_valid && first_v_a < 0) first_v_a = cyc;
      if (rn_a) rn_seen_a++;
      if (sa.out_valid && sa.out_ready) begin
        if (exp_a.size() == 0) check("stream_a_extra", 1, 0);
        else check("stream_a", 32'(sa.out_data), 32'(exp_a.pop_front()));
        hs_a++;
        last_hs_a = cyc;
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
      end
      prev_stall_a = sa.out_valid && !sa.out_ready;
      prev_data_a  = sa.out_data;
    end
  end

  int first_v_b = -1, first_hs_b = -1, last_hs_b = -1, done_cnt_b = 0, done_cyc_b = -1;

  // Monitor B: stream order, timing of first valid / handshakes, done
  always @(negedge clock) begin
    if (!reset) begin
      if (sb.out_valid && first_v_b < 0) first_v_b = cyc;
      if (sb.out_valid && sb.out_ready) begin
        if (exp_b.size() == 0) check("stream_b_extra", 1, 0);
        else check("stream_b", 32'(sb.out_data), 32'(exp_b.pop_front()));
        if (first_hs_b < 0) first_hs_b = cyc;
        last_hs_b = cyc;
      end
      if (done_b) begin
        done_cnt_b++;
        done_cyc_b = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_a(input logic [DW-1:0] v);
    push_d_a = v; push_a = 1'b1; step(); push_a = 1'b0;
  endtask

  task automatic load_b(input logic [DW-1:0] v);
    push_d_b = v; push_b = 1'b1; step(); push_b = 1'b0;
  endtask

  // Returns the index of the edge that sampled drain; the cycle after edge
  // k is numbered k+1, so "first valid in cycle k+3" means seen after edge k+2.
  task automatic pulse_drain_a(output int d);
    drain_a = 1'b1; step(); d = cyc; drain_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 100 && done_cnt_a == 0; i++) step();
    repeat (4) step();
  endtask

  // ---------------- stimulus ----------------
  int d;

  initial begin
    sa.out_ready = 1'b0;
    sb.out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_valid_a", sa.out_valid, 0);
    check("rst_data_a", sa.out_data, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_pcnt_a", pcnt_a, 0);
    check("rst_rn_a", rn_a, 0);
    check("rst_state_a", st_a, ST_IDLE);
    check("rst_valid_b", sb.out_valid, 0);
    check("rst_pcnt_b", pcnt_b, 0);
    step();

    // Basic drain, out_ready held high
    for (int i = 0; i < 7; i++) load_a(words[i]);
    for (int i = 6; i >= 0; i--) exp_a.push_back(words[i]);
    sa.out_ready = 1'b1;
    first_v_a = -1; done_cnt_a = 0;
    pulse_drain_a(d);
    wait_done_a();
    check("basic_left_a", exp_a.size(), 0);
    check("basic_first_valid_cycle", first_v_a - d + 1, 3);
    check("basic_pcnt_a", pcnt_a, 7);
    check("basic_done_pulses", done_cnt_a, 1);
    check("basic_done_after_last_hs", done_cyc_a - last_hs_a, 1);
    check("basic_pcnt_held_idle", {st_a, pcnt_a}, {ST_IDLE, 8'd7});

    // Empty LIFO
    first_v_a = -1; done_cnt_a = 0; rn_seen_a = 0;
    pulse_drain_a(d);
    wait_done_a();
    check("empty_no_valid", first_v_a < 0, 1);
    check("empty_no_rn", rn_seen_a, 0);
    check("empty_done_cycle", done_cyc_a - d + 1, 3);
    check("empty_done_pulses", done_cnt_a, 1);
    check("empty_pcnt", pcnt_a, 0);

    // Backpressure 1,0,0,1 with a drain re-pulse while busy
    for (int i = 0; i < 7; i++) load_a(words[i]);
    for (int i = 6; i >= 0; i--) exp_a.push_back(words[i]);
    done_cnt_a = 0;
    pulse_drain_a(d);
    for (int i = 0; i < 300 && done_cnt_a == 0; i++) begin
      sa.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      if (i == 2) begin
        check("redrain_in_drain_state", st_a, ST_DRAIN);
        drain_a = 1'b1;
      end else begin
        drain_a = 1'b0;
      end
      step();
    end
    drain_a = 1'b0;
    sa.out_ready = 1'b1;
    repeat (6) step();
    check("bp_left_a", exp_a.size(), 0);
    check("bp_done_pulses", done_cnt_a, 1);
    check("bp_pcnt_a", pcnt_a, 7);
    check("bp_done_after_last_hs", done_cyc_a - last_hs_a, 1);

    // Reset mid-drain: stall after 15,65 popped, release one transfer (15),
    // which lets exactly one more pop (70) through, then stall and reset.
    for (int i = 0; i < 7; i++) load_a(words[i]);
    exp_a.push_back(8'd15);
    sa.out_ready = 1'b0;
    done_cnt_a = 0;
    pulse_drain_a(d);
    repeat (6) step();
    sa.out_ready = 1'b1;
    step();
    sa.out_ready = 1'b0;
    repeat (3) step();
    check("mid_left_before_reset", exp_a.size(), 0);
    check("mid_busy_before_reset", busy_a, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", sa.out_valid, 0);
    check("mid_rst_data", sa.out_data, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_pcnt", pcnt_a, 0);
    check("mid_rst_rn", rn_a, 0);
    check("mid_lifo_left", ptr_a, 4);
    drop_a = pops_a - hs_a;
    step();
    exp_a.push_back(8'd40);
    exp_a.push_back(8'd200);
    exp_a.push_back(8'd150);
    exp_a.push_back(8'd100);
    sa.out_ready = 1'b1;
    done_cnt_a = 0;
    pulse_drain_a(d);
    wait_done_a();
    check("redrain_left_a", exp_a.size(), 0);
    check("redrain_pcnt_a", pcnt_a, 4);
    check("redrain_done_pulses", done_cnt_a, 1);

    // READ_LAT = 2 instance
    for (int i = 0; i < 7; i++) load_b(words[i]);
    for (int i = 6; i >= 0; i--) exp_b.push_back(words[i]);
    sb.out_ready = 1'b1;
    drain_b = 1'b1; step(); d = cyc; drain_b = 1'b0;
    for (int i = 0; i < 100 && done_cnt_b == 0; i++) step();
    repeat (4) step();
    check("lat2_left_b", exp_b.size(), 0);
    check("lat2_first_valid_cycle", first_v_b - d + 1, 4);
    check("lat2_throughput_span", last_hs_b - first_hs_b, 6);
    check("lat2_pcnt_b", pcnt_b, 7);
    check("lat2_done_pulses", done_cnt_b, 1);
    check("lat2_done_after_last_hs", done_cyc_b - last_hs_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the run must always end on its own
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
